// File: rtl/knn_pkg.sv
// Shared types and defaults for the k-smallest distance tracker.
package knn_pkg;

  localparam int unsigned DIST_W_DEF = 16;
  localparam int unsigned K_DEF      = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } kst_state_t;

  // Slot layout at the default distance width; cells use the same field order
  // {occupied, distance, group} at whatever width they are built with.
  typedef struct packed {
    logic                  occupied;
    logic [DIST_W_DEF-1:0] distance;
    logic                  group;
  } kst_slot_t;

endpackage

// File: rtl/knn_insert_cell.sv
// One slot of the parallel insertion sorter: keeps, shifts in the previous
// slot, or takes the new sample.
module knn_insert_cell #(
  parameter int unsigned DIST_W = 16
) (
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [DIST_W-1:0] new_dist_i,
  input  logic              new_grp_i,
  input  logic [DIST_W+1:0] own_slot_i,
  input  logic [DIST_W+1:0] prev_slot_i,
  input  logic              prev_lt_i,
  output logic [DIST_W+1:0] next_slot_o,
  output logic              new_lt_o
);

  typedef struct packed {
    logic              occupied;
    logic [DIST_W-1:0] distance;
    logic              group;
  } slot_t;

  slot_t own;
  slot_t prev;
  slot_t nxt;
  logic  lt;

  assign own  = own_slot_i;
  assign prev = prev_slot_i;

  always_comb begin
    // An empty slot loses to every sample, including an all-ones distance.
    lt  = !own.occupied || (new_dist_i < own.distance);
    nxt = own;
    if (clear_i) begin
      nxt.occupied = 1'b0;
      nxt.distance = '1;
      nxt.group    = 1'b0;
    end else if (accept_i) begin
      if (prev_lt_i) begin
        nxt = prev;
      end else if (lt) begin
        nxt.occupied = 1'b1;
        nxt.distance = new_dist_i;
        nxt.group    = new_grp_i;
      end
    end
  end

  assign next_slot_o = nxt;
  assign new_lt_o    = lt;

endmodule

// File: rtl/k_smallest_tracker.sv
// Streaming sorter keeping the K smallest distances and their group bits.
// Define KST_DIST_OUT_EN to expose the sorted distances on o_smallest_distances.
module k_smallest_tracker
  import knn_pkg::*;
#(
  parameter int unsigned DIST_W = DIST_W_DEF,
  parameter int unsigned K      = K_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_valid,
  input  logic [DIST_W-1:0]        i_distance,
  input  logic                     i_group,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic [K-1:0]             o_5_smallest_distances_group_bit,
  output logic [$clog2(K+1)-1:0]   o_fill,
  output logic [CNT_W-1:0]         o_sample_cnt,
`ifdef KST_DIST_OUT_EN
  output logic [K*DIST_W-1:0]      o_smallest_distances,
`endif
  output logic                     o_done
);

  localparam int unsigned FILL_W = $clog2(K + 1);
  localparam int unsigned SLOT_W = DIST_W + 2;
  localparam logic [SLOT_W-1:0] EMPTY_SLOT = {1'b0, {DIST_W{1'b1}}, 1'b0};

  kst_state_t        state_q, state_d;
  logic [SLOT_W-1:0] slot_q [K];
  logic [SLOT_W-1:0] slot_d [K];
  logic [K-1:0]      lt;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  // A start pulse always wins over a coincident sample.
  assign accept = (state_q == ACCUM) && i_valid && !i_start;

  for (genvar j = 0; j < K; j++) begin : g_cell
    if (j == 0) begin : g_head
      knn_insert_cell #(.DIST_W(DIST_W)) u_cell (
        .clear_i     (i_start),
        .accept_i    (accept),
        .new_dist_i  (i_distance),
        .new_grp_i   (i_group),
        .own_slot_i  (slot_q[j]),
        .prev_slot_i (EMPTY_SLOT),
        .prev_lt_i   (1'b0),
        .next_slot_o (slot_d[j]),
        .new_lt_o    (lt[j])
      );
    end else begin : g_body
      knn_insert_cell #(.DIST_W(DIST_W)) u_cell (
        .clear_i     (i_start),
        .accept_i    (accept),
        .new_dist_i  (i_distance),
        .new_grp_i   (i_group),
        .own_slot_i  (slot_q[j]),
        .prev_slot_i (slot_q[j-1]),
        .prev_lt_i   (lt[j-1]),
        .next_slot_o (slot_d[j]),
        .new_lt_o    (lt[j])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    o_ready = 1'b0;
    o_done  = 1'b0;
    unique case (state_q)
      IDLE:  ;
      ACCUM: begin
        o_ready = 1'b1;
        if (accept && i_last) state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_start) begin
      state_d = ACCUM;
      fill_d  = '0;
      cnt_d   = '0;
    end else if (accept) begin
      // Last slot is empty whenever the table is not full, so lt[K-1] is set.
      if (lt[K-1] && (fill_q != FILL_W'(K))) fill_d = fill_q + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      fill_q  <= '0;
      cnt_q   <= '0;
      for (int unsigned j = 0; j < K; j++) slot_q[j] <= EMPTY_SLOT;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      for (int unsigned j = 0; j < K; j++) slot_q[j] <= slot_d[j];
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < K; j++) o_5_smallest_distances_group_bit[j] = slot_q[j][0];
  end

  assign o_fill       = fill_q;
  assign o_sample_cnt = cnt_q;

`ifdef KST_DIST_OUT_EN
  always_comb begin
    for (int unsigned j = 0; j < K; j++) o_smallest_distances[j*DIST_W +: DIST_W] = slot_q[j][DIST_W:1];
  end
`else
  // Distance registers stay internal.
`endif

endmodule

// File: tb/tb_k_smallest_tracker.sv
// Directed self-checking bench for k_smallest_tracker (K=5, DIST_W=16).
module tb_k_smallest_tracker;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_valid;
  logic [15:0] i_distance;
  logic        i_group;
  logic        i_last;
  logic        o_ready;
  logic [4:0]  o_grp;
  logic [2:0]  o_fill;
  logic [15:0] o_sample_cnt;
  logic        o_done;
`ifdef KST_DIST_OUT_EN
  logic [79:0] o_smallest_distances;
`endif

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_done === 1'b1) done_seen++;

  k_smallest_tracker #(.DIST_W(16), .K(5), .CNT_W(16)) dut (
    .i_clk                            (i_clk),
    .i_rst                            (i_rst),
    .i_start                          (i_start),
    .i_valid                          (i_valid),
    .i_distance                       (i_distance),
    .i_group                          (i_group),
    .i_last                           (i_last),
    .o_ready                          (o_ready),
    .o_5_smallest_distances_group_bit (o_grp),
    .o_fill                           (o_fill),
    .o_sample_cnt                     (o_sample_cnt),
`ifdef KST_DIST_OUT_EN
    .o_smallest_distances             (o_smallest_distances),
`endif
    .o_done                           (o_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic g, input logic l);
    i_valid    = 1'b1;
    i_distance = d;
    i_group    = g;
    i_last     = l;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0;
    i_distance = '0; i_group = 1'b0; i_last = 1'b0;
    #2;
    chk("rst_ready", o_ready, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_fill",  o_fill, 0);
    chk("rst_cnt",   o_sample_cnt, 0);
    chk("rst_grp",   o_grp, 0);
    #10 i_rst = 1'b0;
    tick();

    // Scenario 1: basic sort
    start();
    chk("s1_ready", o_ready, 1);
    send(16'd9, 1'b1, 1'b0);
    send(16'd3, 1'b0, 1'b0);
    send(16'd7, 1'b1, 1'b0);
    chk("s1_grp3",  o_grp, 5'b00110);
    chk("s1_fill3", o_fill, 3);
    send(16'd1, 1'b0, 1'b0);
    send(16'd5, 1'b1, 1'b0);
    send(16'd8, 1'b1, 1'b1);
    chk("s1_done",  o_done, 1);
    chk("s1_grp",   o_grp, 5'b11100);
    chk("s1_cnt",   o_sample_cnt, 6);
    chk("s1_fill",  o_fill, 5);
`ifdef KST_DIST_OUT_EN
    chk("s1_dist",  o_smallest_distances, {16'd8, 16'd7, 16'd5, 16'd3, 16'd1});
`endif
    tick();
    chk("s1_done_drop", o_done, 0);
    chk("s1_idle_ready", o_ready, 0);
    chk("s1_grp_held", o_grp, 5'b11100);
    chk("s1_done_cnt", done_seen, 1);

    // Scenario 2: ties, short stream, i_last without i_valid
    start();
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    chk("s2_last_novalid_done", o_done, 0);
    chk("s2_last_novalid_ready", o_ready, 1);
    send(16'd4, 1'b1, 1'b0);
    send(16'd4, 1'b0, 1'b0);
    send(16'd4, 1'b1, 1'b0);
    send(16'd2, 1'b0, 1'b1);
    chk("s2_done", o_done, 1);
    chk("s2_grp",  o_grp, 5'b01010);
    chk("s2_fill", o_fill, 4);
    chk("s2_cnt",  o_sample_cnt, 4);
    tick();

    // Scenario 3: all-ones distance, drop when full, valid in IDLE
    start();
    send(16'hFFFF, 1'b1, 1'b0);
    chk("s3_ffff_fill", o_fill, 1);
    chk("s3_ffff_grp",  o_grp, 5'b00001);
    send(16'd10, 1'b0, 1'b0);
    send(16'd20, 1'b0, 1'b0);
    send(16'd30, 1'b0, 1'b0);
    send(16'd40, 1'b0, 1'b0);
    chk("s3_full_grp", o_grp, 5'b10000);
    send(16'hFFFF, 1'b0, 1'b1);
    chk("s3_drop_grp",  o_grp, 5'b10000);
    chk("s3_drop_cnt",  o_sample_cnt, 6);
    chk("s3_drop_fill", o_fill, 5);
    chk("s3_done", o_done, 1);
    tick();
    send(16'd0, 1'b1, 1'b0);
    chk("s3_idle_cnt", o_sample_cnt, 6);
    chk("s3_idle_grp", o_grp, 5'b10000);

    // Scenario 4: abort mid-stream, start with coincident sample
    start();
    send(16'd1, 1'b1, 1'b0);
    send(16'd2, 1'b1, 1'b0);
    send(16'd3, 1'b1, 1'b0);
    i_start = 1'b1;
    send(16'd0, 1'b1, 1'b0);
    i_start = 1'b0;
    chk("s4_clr_fill", o_fill, 0);
    chk("s4_clr_cnt",  o_sample_cnt, 0);
    chk("s4_clr_grp",  o_grp, 0);
    chk("s4_clr_done", o_done, 0);
    send(16'd50, 1'b1, 1'b0);
    send(16'd40, 1'b1, 1'b0);
    send(16'd30, 1'b0, 1'b0);
    send(16'd20, 1'b0, 1'b0);
    send(16'd10, 1'b1, 1'b1);
    chk("s4_grp",  o_grp, 5'b11001);
    chk("s4_done", o_done, 1);
    chk("s4_cnt",  o_sample_cnt, 5);
    tick();
    chk("s4_done_cnt", done_seen, 4);

    // Scenario 5: asynchronous reset mid-accept
    start();
    send(16'd100, 1'b1, 1'b0);
    send(16'd200, 1'b1, 1'b0);
    chk("s5_pre_fill", o_fill, 2);
    chk("s5_pre_grp",  o_grp, 5'b00011);
    i_valid = 1'b1; i_distance = 16'd50; i_group = 1'b1;
    #2 i_rst = 1'b1;
    #1;
    chk("s5_rst_fill",  o_fill, 0);
    chk("s5_rst_grp",   o_grp, 0);
    chk("s5_rst_cnt",   o_sample_cnt, 0);
    chk("s5_rst_ready", o_ready, 0);
    #4 i_rst = 1'b0;
    tick();
    i_valid = 1'b0;
    chk("s5_ign_cnt",   o_sample_cnt, 0);
    chk("s5_ign_fill",  o_fill, 0);
    chk("s5_ign_ready", o_ready, 0);
    start();
    chk("s5_restart_ready", o_ready, 1);
    tick();
    chk("s5_done_cnt", done_seen, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
